// File: rtl/mem2axil_master.sv
// mem2axil_master
//   Bridges a valid/ready memory request port onto an AXI4-Lite master.
//   Each accepted request becomes one AXI4-Lite read or write. Only one
//   transaction is outstanding at a time. Completion is a one-cycle pulse on
//   o_mem_rvalid that carries read data and an error flag.
//
// Ports
//   i_aclk, i_areset_n       clock, asynchronous active-low reset
//   i_mem_*/o_mem_*          requester side: req/gnt handshake, we, addr,
//                            wdata, wstrb; completion rvalid/rdata/err
//   o_m_aw*/o_m_w*/o_m_b*    AXI4-Lite write address, write data and write
//                            response channels
//   o_m_ar*/o_m_r*           AXI4-Lite read address and read data channels
//   o_timeout                sticky watchdog flag (MEM2AXIL_TIMEOUT_EN only)
//
// Configuration
//   DATA_WIDTH must be 32 or 64.
//   `define MEM2AXIL_TIMEOUT_EN adds a watchdog. When a transaction stays
//   non-IDLE for TIMEOUT_CYCLES cycles, the watchdog aborts it and returns
//   an error completion.
module mem2axil_master #(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic                      i_aclk,
  input  logic                      i_areset_n,
  input  logic                      i_mem_req,
  output logic                      o_mem_gnt,
  input  logic                      i_mem_we,
  input  logic [ADDR_WIDTH-1:0]     i_mem_addr,
  input  logic [DATA_WIDTH-1:0]     i_mem_wdata,
  input  logic [DATA_WIDTH/8-1:0]   i_mem_wstrb,
  output logic                      o_mem_rvalid,
  output logic [DATA_WIDTH-1:0]     o_mem_rdata,
  output logic                      o_mem_err,
  output logic                      o_m_awvalid,
  input  logic                      i_m_awready,
  output logic [ADDR_WIDTH-1:0]     o_m_awaddr,
  output logic [2:0]                o_m_awprot,
  output logic                      o_m_wvalid,
  input  logic                      i_m_wready,
  output logic [DATA_WIDTH-1:0]     o_m_wdata,
  output logic [DATA_WIDTH/8-1:0]   o_m_wstrb,
  input  logic                      i_m_bvalid,
  output logic                      o_m_bready,
  input  logic [1:0]                i_m_bresp,
  output logic                      o_m_arvalid,
  input  logic                      i_m_arready,
  output logic [ADDR_WIDTH-1:0]     o_m_araddr,
  output logic [2:0]                o_m_arprot,
  input  logic                      i_m_rvalid,
  output logic                      o_m_rready,
  input  logic [1:0]                i_m_rresp,
  input  logic [DATA_WIDTH-1:0]     i_m_rdata
`ifdef MEM2AXIL_TIMEOUT_EN
  ,
  output logic                      o_timeout
`endif
);

  localparam int unsigned STRB_W = DATA_WIDTH / 8;
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(STRB_W - 1);

  typedef enum logic [2:0] {IDLE, WADDR, WRESP, RADDR, RDATA} state_e;

  state_e                state_q, state_d;
  logic                  awvalid_q, awvalid_d;
  logic                  wvalid_q, wvalid_d;
  logic                  bready_q, bready_d;
  logic                  arvalid_q, arvalid_d;
  logic                  rready_q, rready_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [STRB_W-1:0]     wstrb_q, wstrb_d;
  logic                  mem_rvalid_q, mem_rvalid_d;
  logic [DATA_WIDTH-1:0] mem_rdata_q, mem_rdata_d;
  logic                  mem_err_q, mem_err_d;
  logic                  accept;
  logic                  aw_done, w_done;

`ifdef MEM2AXIL_TIMEOUT_EN
  localparam int unsigned CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 16) ? $clog2(TIMEOUT_CYCLES + 1) : 16;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_q, timeout_d;
  logic             unused_cfg;
  assign unused_cfg = ^{i_m_bresp[0], i_m_rresp[0]};
`else
  logic             unused_cfg;
  assign unused_cfg = ^{i_m_bresp[0], i_m_rresp[0], 32'(TIMEOUT_CYCLES)};
`endif

  assign accept = i_mem_req && (state_q == IDLE);
  // A channel counts as done if it already handshook or handshakes this cycle.
  assign aw_done = !awvalid_q || i_m_awready;
  assign w_done  = !wvalid_q || i_m_wready;

  always_comb begin
    state_d      = state_q;
    awvalid_d    = awvalid_q;
    wvalid_d     = wvalid_q;
    bready_d     = bready_q;
    arvalid_d    = arvalid_q;
    rready_d     = rready_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    wstrb_d      = wstrb_q;
    mem_rvalid_d = 1'b0;
    mem_rdata_d  = mem_rdata_q;
    mem_err_d    = mem_err_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          addr_d  = i_mem_addr & ALIGN_MASK;
          wdata_d = i_mem_wdata;
          wstrb_d = i_mem_wstrb;
          if (i_mem_we) begin
            state_d   = WADDR;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
          end else begin
            state_d   = RADDR;
            arvalid_d = 1'b1;
          end
        end
      end
      WADDR: begin
        if (awvalid_q && i_m_awready) awvalid_d = 1'b0;
        if (wvalid_q && i_m_wready)   wvalid_d  = 1'b0;
        if (aw_done && w_done) begin
          state_d  = WRESP;
          bready_d = 1'b1;
        end
      end
      WRESP: begin
        if (i_m_bvalid) begin
          state_d      = IDLE;
          bready_d     = 1'b0;
          mem_rvalid_d = 1'b1;
          mem_rdata_d  = '0;
          mem_err_d    = i_m_bresp[1];
        end
      end
      RADDR: begin
        if (i_m_arready) begin
          state_d   = RDATA;
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
        end
      end
      RDATA: begin
        if (i_m_rvalid) begin
          state_d      = IDLE;
          rready_d     = 1'b0;
          mem_rvalid_d = 1'b1;
          mem_rdata_d  = i_m_rdata;
          mem_err_d    = i_m_rresp[1];
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

`ifdef MEM2AXIL_TIMEOUT_EN
    cnt_d     = cnt_q;
    timeout_d = timeout_q;
    if (accept) begin
      cnt_d = '0;
    end else if (state_q != IDLE) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    // Abort on the cycle the counter reaches the limit; this overrides any
    // handshake completing in the same cycle.
    if ((state_q != IDLE) && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1))) begin
      state_d      = IDLE;
      awvalid_d    = 1'b0;
      wvalid_d     = 1'b0;
      bready_d     = 1'b0;
      arvalid_d    = 1'b0;
      rready_d     = 1'b0;
      mem_rvalid_d = 1'b1;
      mem_rdata_d  = '0;
      mem_err_d    = 1'b1;
      timeout_d    = 1'b1;
    end
`endif
  end

  always_ff @(posedge i_aclk or negedge i_areset_n) begin
    if (!i_areset_n) begin
      state_q      <= IDLE;
      awvalid_q    <= 1'b0;
      wvalid_q     <= 1'b0;
      bready_q     <= 1'b0;
      arvalid_q    <= 1'b0;
      rready_q     <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      wstrb_q      <= '0;
      mem_rvalid_q <= 1'b0;
      mem_rdata_q  <= '0;
      mem_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      awvalid_q    <= awvalid_d;
      wvalid_q     <= wvalid_d;
      bready_q     <= bready_d;
      arvalid_q    <= arvalid_d;
      rready_q     <= rready_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      wstrb_q      <= wstrb_d;
      mem_rvalid_q <= mem_rvalid_d;
      mem_rdata_q  <= mem_rdata_d;
      mem_err_q    <= mem_err_d;
    end
  end

`ifdef MEM2AXIL_TIMEOUT_EN
  always_ff @(posedge i_aclk or negedge i_areset_n) begin
    if (!i_areset_n) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign o_timeout = timeout_q;
`endif

  assign o_mem_gnt    = (state_q == IDLE);
  assign o_mem_rvalid = mem_rvalid_q;
  assign o_mem_rdata  = mem_rdata_q;
  assign o_mem_err    = mem_err_q;
  assign o_m_awvalid  = awvalid_q;
  assign o_m_awaddr   = addr_q;
  assign o_m_awprot   = 3'b000;
  assign o_m_wvalid   = wvalid_q;
  assign o_m_wdata    = wdata_q;
  assign o_m_wstrb    = wstrb_q;
  assign o_m_bready   = bready_q;
  assign o_m_arvalid  = arvalid_q;
  assign o_m_araddr   = addr_q;
  assign o_m_arprot   = 3'b000;
  assign o_m_rready   = rready_q;

endmodule

// File: tb/tb_mem2axil_master.sv
// tb_mem2axil_master
//   Directed test for mem2axil_master. The bench acts as requester and as
//   AXI4-Lite slave. It pushes expected completions to a scoreboard queue
//   when each request is driven. A monitor pops the queue on every
//   o_mem_rvalid pulse and compares the result.
module tb_mem2axil_master;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;

  logic          clk = 1'b0;
  logic          i_areset_n;
  logic          i_mem_req;
  logic          o_mem_gnt;
  logic          i_mem_we;
  logic [AW-1:0] i_mem_addr;
  logic [DW-1:0] i_mem_wdata;
  logic [SW-1:0] i_mem_wstrb;
  logic          o_mem_rvalid;
  logic [DW-1:0] o_mem_rdata;
  logic          o_mem_err;
  logic          o_m_awvalid;
  logic          i_m_awready;
  logic [AW-1:0] o_m_awaddr;
  logic [2:0]    o_m_awprot;
  logic          o_m_wvalid;
  logic          i_m_wready;
  logic [DW-1:0] o_m_wdata;
  logic [SW-1:0] o_m_wstrb;
  logic          i_m_bvalid;
  logic          o_m_bready;
  logic [1:0]    i_m_bresp;
  logic          o_m_arvalid;
  logic          i_m_arready;
  logic [AW-1:0] o_m_araddr;
  logic [2:0]    o_m_arprot;
  logic          i_m_rvalid;
  logic          o_m_rready;
  logic [1:0]    i_m_rresp;
  logic [DW-1:0] i_m_rdata;
`ifdef MEM2AXIL_TIMEOUT_EN
  logic          o_timeout;
  int unsigned   to_k;
  logic          to_seen;
`endif

  int unsigned   n_checks = 0;
  int unsigned   n_fail   = 0;
  int unsigned   n_cpl    = 0;
  int unsigned   n_expect = 0;
  logic [32:0]   exp_q[$];   // {err, rdata}
  logic [32:0]   exp_e;

  always #5 clk = ~clk;

  mem2axil_master #(
    .ADDR_WIDTH     (AW),
    .DATA_WIDTH     (DW),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .i_aclk       (clk),
    .i_areset_n   (i_areset_n),
    .i_mem_req    (i_mem_req),
    .o_mem_gnt    (o_mem_gnt),
    .i_mem_we     (i_mem_we),
    .i_mem_addr   (i_mem_addr),
    .i_mem_wdata  (i_mem_wdata),
    .i_mem_wstrb  (i_mem_wstrb),
    .o_mem_rvalid (o_mem_rvalid),
    .o_mem_rdata  (o_mem_rdata),
    .o_mem_err    (o_mem_err),
    .o_m_awvalid  (o_m_awvalid),
    .i_m_awready  (i_m_awready),
    .o_m_awaddr   (o_m_awaddr),
    .o_m_awprot   (o_m_awprot),
    .o_m_wvalid   (o_m_wvalid),
    .i_m_wready   (i_m_wready),
    .o_m_wdata    (o_m_wdata),
    .o_m_wstrb    (o_m_wstrb),
    .i_m_bvalid   (i_m_bvalid),
    .o_m_bready   (o_m_bready),
    .i_m_bresp    (i_m_bresp),
    .o_m_arvalid  (o_m_arvalid),
    .i_m_arready  (i_m_arready),
    .o_m_araddr   (o_m_araddr),
    .o_m_arprot   (o_m_arprot),
    .i_m_rvalid   (i_m_rvalid),
    .o_m_rready   (o_m_rready),
    .i_m_rresp    (i_m_rresp),
    .i_m_rdata    (i_m_rdata)
`ifdef MEM2AXIL_TIMEOUT_EN
    ,
    .o_timeout    (o_timeout)
`endif
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Scoreboard monitor: every completion pulse consumes one expectation.
  always @(negedge clk) begin
    if (o_mem_rvalid === 1'b1) begin
      n_cpl++;
      if (exp_q.size() == 0) begin
        check("unexpected_cpl", 64'(1), 64'(0));
      end else begin
        exp_e = exp_q.pop_front();
        check("cpl_rdata", 64'(o_mem_rdata), 64'(exp_e[31:0]));
        check("cpl_err", 64'(o_mem_err), 64'(exp_e[32]));
      end
    end
  end

  task automatic read_txn(input logic [31:0] addr, input int unsigned ar_wait,
                          input logic [31:0] rdata, input logic [1:0] rresp,
                          input logic hold_next, input logic [31:0] next_addr);
    check("gnt_before_rd", 64'(o_mem_gnt), 64'(1));
    i_mem_req  = 1'b1;
    i_mem_we   = 1'b0;
    i_mem_addr = addr;
    exp_q.push_back({rresp[1], rdata});
    n_expect++;
    step();
    if (hold_next) i_mem_addr = next_addr;
    else i_mem_req = 1'b0;
    for (int unsigned c = 0; c <= ar_wait; c++) begin
      check("arvalid_held", 64'(o_m_arvalid), 64'(1));
      check("araddr", 64'(o_m_araddr), 64'(addr & 32'hFFFF_FFFC));
      check("gnt_busy_rd", 64'(o_mem_gnt), 64'(0));
      if (c == 0) check("arprot", 64'(o_m_arprot), 64'(0));
      i_m_arready = (c == ar_wait);
      step();
    end
    i_m_arready = 1'b0;
    check("arvalid_drop", 64'(o_m_arvalid), 64'(0));
    check("rready", 64'(o_m_rready), 64'(1));
    i_m_rvalid = 1'b1;
    i_m_rdata  = rdata;
    i_m_rresp  = rresp;
    step();
    i_m_rvalid = 1'b0;
    i_m_rdata  = '0;
    i_m_rresp  = 2'b00;
    check("rready_drop", 64'(o_m_rready), 64'(0));
    check("gnt_on_cpl_rd", 64'(o_mem_gnt), 64'(1));
  endtask

  task automatic write_txn(input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] wstrb, input int unsigned aw_wait,
                           input int unsigned w_wait, input logic [1:0] bresp,
                           input logic do_reset);
    int unsigned last;
    last = (aw_wait > w_wait) ? aw_wait : w_wait;
    check("gnt_before_wr", 64'(o_mem_gnt), 64'(1));
    i_mem_req   = 1'b1;
    i_mem_we    = 1'b1;
    i_mem_addr  = addr;
    i_mem_wdata = wdata;
    i_mem_wstrb = wstrb;
    exp_q.push_back({bresp[1], 32'h0});
    step();
    i_mem_req = 1'b0;
    i_mem_we  = 1'b0;
    for (int unsigned c = 0; c <= last; c++) begin
      check("awvalid", 64'(o_m_awvalid), 64'(c <= aw_wait));
      check("wvalid", 64'(o_m_wvalid), 64'(c <= w_wait));
      check("bready_early", 64'(o_m_bready), 64'(0));
      if (c == 0) begin
        check("awaddr", 64'(o_m_awaddr), 64'(addr & 32'hFFFF_FFFC));
        check("wdata", 64'(o_m_wdata), 64'(wdata));
        check("wstrb", 64'(o_m_wstrb), 64'(wstrb));
        check("awprot", 64'(o_m_awprot), 64'(0));
      end
      i_m_awready = (c == aw_wait);
      i_m_wready  = (c == w_wait);
      step();
    end
    i_m_awready = 1'b0;
    i_m_wready  = 1'b0;
    check("awvalid_done", 64'(o_m_awvalid), 64'(0));
    check("wvalid_done", 64'(o_m_wvalid), 64'(0));
    check("bready", 64'(o_m_bready), 64'(1));
    if (do_reset) begin
      void'(exp_q.pop_back());
      #2 i_areset_n = 1'b0;
      #1;
      check("rst_bready", 64'(o_m_bready), 64'(0));
      check("rst_awvalid", 64'(o_m_awvalid), 64'(0));
      check("rst_awaddr", 64'(o_m_awaddr), 64'(0));
      check("rst_wdata", 64'(o_m_wdata), 64'(0));
      check("rst_mem_rvalid", 64'(o_mem_rvalid), 64'(0));
      check("rst_mem_err", 64'(o_mem_err), 64'(0));
      check("rst_gnt", 64'(o_mem_gnt), 64'(1));
      // Late B beat during and after reset must not be acknowledged.
      i_m_bvalid = 1'b1;
      i_m_bresp  = bresp;
      step();
      check("late_b_in_rst", 64'(o_m_bready), 64'(0));
      i_areset_n = 1'b1;
      step();
      check("late_b_after_rst", 64'(o_m_bready), 64'(0));
      check("no_cpl_after_rst", 64'(o_mem_rvalid), 64'(0));
      i_m_bvalid = 1'b0;
      i_m_bresp  = 2'b00;
      step();
    end else begin
      n_expect++;
      i_m_bvalid = 1'b1;
      i_m_bresp  = bresp;
      step();
      i_m_bvalid = 1'b0;
      i_m_bresp  = 2'b00;
      check("bready_drop", 64'(o_m_bready), 64'(0));
      check("gnt_on_cpl_wr", 64'(o_mem_gnt), 64'(1));
    end
  endtask

  // One cycle after a completion: pulse is over, results are held.
  task automatic check_hold(input logic [31:0] rdata, input logic err);
    step();
    check("rvalid_one_cycle", 64'(o_mem_rvalid), 64'(0));
    check("rdata_hold", 64'(o_mem_rdata), 64'(rdata));
    check("err_hold", 64'(o_mem_err), 64'(err));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    i_areset_n  = 1'b0;
    i_mem_req   = 1'b0;
    i_mem_we    = 1'b0;
    i_mem_addr  = '0;
    i_mem_wdata = '0;
    i_mem_wstrb = '0;
    i_m_awready = 1'b0;
    i_m_wready  = 1'b0;
    i_m_bvalid  = 1'b0;
    i_m_bresp   = 2'b00;
    i_m_arready = 1'b0;
    i_m_rvalid  = 1'b0;
    i_m_rresp   = 2'b00;
    i_m_rdata   = '0;
    repeat (3) step();
    check("reset_gnt", 64'(o_mem_gnt), 64'(1));
    check("reset_awvalid", 64'(o_m_awvalid), 64'(0));
    check("reset_arvalid", 64'(o_m_arvalid), 64'(0));
    check("reset_rready", 64'(o_m_rready), 64'(0));
    check("reset_mem_rvalid", 64'(o_mem_rvalid), 64'(0));
    check("reset_mem_rdata", 64'(o_mem_rdata), 64'(0));
    i_areset_n = 1'b1;
    step();

    // Zero-wait read.
    read_txn(32'h0000_1004, 0, 32'hDEAD_BEEF, 2'b00, 1'b0, 32'h0);
    check_hold(32'hDEAD_BEEF, 1'b0);

    // Writes: W before AW by 3 cycles, both together, AW before W with wstrb=0.
    write_txn(32'h0000_2003, 32'h1234_5678, 4'b0011, 3, 0, 2'b00, 1'b0);
    check_hold(32'h0, 1'b0);
    write_txn(32'h0000_3000, 32'hCAFE_0001, 4'b1111, 0, 0, 2'b00, 1'b0);
    write_txn(32'h0000_300E, 32'hCAFE_0002, 4'b0000, 0, 2, 2'b00, 1'b0);

    // Error responses.
    read_txn(32'h0000_4008, 1, 32'hA5A5_A5A5, 2'b10, 1'b0, 32'h0);
    check_hold(32'hA5A5_A5A5, 1'b1);
    write_txn(32'h0000_4100, 32'h0BAD_0BAD, 4'b1100, 1, 1, 2'b11, 1'b0);
    check_hold(32'h0, 1'b1);

    // AR backpressure with a second request held pending.
    read_txn(32'h0000_5000, 10, 32'h1111_1111, 2'b00, 1'b1, 32'h0000_6000);
    read_txn(32'h0000_6000, 0, 32'h2222_2222, 2'b00, 1'b0, 32'h0);
    check_hold(32'h2222_2222, 1'b0);

    // Reset while waiting for B, then a normal read.
    write_txn(32'h0000_7000, 32'h7777_7777, 4'b1111, 0, 0, 2'b10, 1'b1);
    read_txn(32'h0000_8000, 0, 32'hCAFE_F00D, 2'b00, 1'b0, 32'h0);
    check_hold(32'hCAFE_F00D, 1'b0);

`ifdef MEM2AXIL_TIMEOUT_EN
    check("timeout_clear", 64'(o_timeout), 64'(0));
    i_mem_req  = 1'b1;
    i_mem_we   = 1'b0;
    i_mem_addr = 32'h0000_9000;
    exp_q.push_back({1'b1, 32'h0});
    n_expect++;
    step();
    i_mem_req = 1'b0;
    to_k      = 0;
    to_seen   = 1'b0;
    while (!to_seen && to_k < 40) begin
      to_k++;
      if (o_mem_rvalid === 1'b1) to_seen = 1'b1;
      else step();
    end
    check("timeout_cycle", 64'(to_k), 64'(17));
    check("timeout_flag", 64'(o_timeout), 64'(1));
    check("timeout_arvalid", 64'(o_m_arvalid), 64'(0));
    repeat (5) step();
    check("timeout_sticky", 64'(o_timeout), 64'(1));
`endif

    repeat (3) step();
    check("sb_empty", 64'(exp_q.size()), 64'(0));
    check("cpl_count", 64'(n_cpl), 64'(n_expect));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
